risc16_cpu: RTL and testbench
=============================

Name: risc16_cpu

Overview:
- Small 16-bit multicycle RISC CPU core.
- Fetches 16-bit instructions from an external ROM (6-bit word address) and executes them against a 16x16 register file.
- Accesses a 64-word external RAM over a shared bidirectional data bus.
- Sits between the instruction ROM and the data RAM at the top of the design; a debug bus exposes the writeback value.

Parameters:
- None. Widths are fixed: data 16, ROM/RAM address 6, 16 registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- data_from_rom  input  16  instruction word at address_to_rom
- address_to_rom  output  6  program counter
- enable_to_rom  output  1  ROM read enable
- data_ram  inout  16  RAM data bus; driven by the CPU only during a store, otherwise high-Z
- address_to_ram  output  6  RAM word address
- write_enable_to_ram  output  1  RAM write strobe
- read_enable_to_ram  output  1  RAM read strobe
- enable_ram_read  output  1  RAM chip enable, high for any RAM access
- D  output  16  debug: last register-file writeback value

Behaviour:
- Reset, sampled at a rising edge while reset==0:
  - PC=0, IR=0, all registers R0..R15=0, D=0, state=FETCH.
  - While reset is low, all enables/strobes are 0 and data_ram is Z.
- Two-state FSM; each instruction takes exactly 2 cycles.
  - FETCH: enable_to_rom=1, address_to_rom=PC. At the edge, IR<=data_from_rom; go to EXEC.
  - EXEC: decode IR, update registers, PC and D at the edge; go to FETCH.
  - address_to_rom holds PC in both states.
- Encoding: op=IR[15:12], rd=IR[11:8], rs=IR[7:4], fn=IR[3:0], imm8=IR[7:0].
- op 0x0, ALU, rd <= f(R[rd], R[rs]):
  - fn 0 MOV (R[rs])
  - fn 1 ADD
  - fn 2 SUB (rd-rs)
  - fn 3 AND
  - fn 4 OR
  - fn 5 XOR
  - fn 6 NOT R[rs]
  - fn 7 SHL R[rd] by 1
  - fn 8 SHR logical R[rd] by 1
  - fn 9-F: no writeback
  - Arithmetic is 16-bit modulo; carry discarded.
- op 0x8, LI: rd <= sign-extend(imm8).
- op 0x9, LW: rd <= data_ram, sampled at the EXEC edge.
  - During EXEC: address_to_ram=imm8[5:0], read_enable_to_ram=1, enable_ram_read=1.
- op 0xA, SW: mem[imm8[5:0]] <= R[rd].
  - During EXEC: write_enable_to_ram=1, enable_ram_read=1, data_ram driven with R[rd].
- op 0xB, BZ: if R[rd]==0 then PC <= PC+1+sext(imm8), truncated to 6 bits (wraps mod 64); else PC <= PC+1.
- op 0xC, JMP: PC <= imm8[5:0].
- All other opcodes: NOP, PC <= PC+1.
- Non-branch instructions: PC <= PC+1, wrapping 63->0.
- RAM signals:
  - Asserted only in EXEC of LW/SW; 0 in FETCH and for all other instructions.
  - address_to_ram is 0 when no RAM access is in progress.
- D updates to the written value on every register writeback and holds otherwise.
- R0 is a normal writable register.
- ALU source operands are read before the write, so rd==rs uses the old value.
- Reset mid-instruction aborts it: no writeback, no RAM write, next cycle is FETCH of address 0.

Optional Feature:
- Macro CPU_BNZ_EN.
- When defined: op 0xD is BNZ. It branches when R[rd]!=0, using the same offset and wrap rules as BZ.
- When undefined: op 0xD is a NOP (PC+1).

Test Plan:
- Reset low one edge, then high → address_to_rom=0, enable_to_rom=1 in the first cycle; PC advances by 1 every 2 cycles on NOPs (e.g. 0xF000).
- LI 0x88FF → R8=0xFFFF, D=0xFFFF after EXEC; then BZ 0xB8F0 at PC=p → PC=p+1 (not taken).
- LI 0x8800 then BZ 0xB8F0 at PC=5 → PC=(5+1-16) mod 64=54.
- data_ram forced to 69, LW 0x9205 → address_to_ram=5, read_enable_to_ram=1 and enable_ram_read=1 for exactly one cycle; R2=0x0045, D=0x0045.
- R3=0x0002, R2=0x0045 then ADD 0x0321 → R3=0x0047; SUB with R3=0, R2=1 → 0xFFFF (wrap); SW 0xA30A → data_ram=R3, write_enable_to_ram=1 for one cycle at address 10, Z otherwise.
- Reset pulsed during EXEC of SW → no write strobe, all registers 0, PC=0.

Source files
------------

// File: rtl/risc16_cpu.sv
// risc16_cpu: 16-bit multicycle RISC core, ROM fetch, shared-bus RAM, optional BNZ under CPU_BNZ_EN.
// Latency: two cycles per instruction (FETCH then EXEC); D reflects a writeback one edge after EXEC.
// Backpressure: none; ROM and RAM are assumed to answer within the same cycle.
module risc16_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_from_rom,
    output logic [5:0]  address_to_rom,
    output logic        enable_to_rom,
    inout  wire  [15:0] data_ram,
    output logic [5:0]  address_to_ram,
    output logic        write_enable_to_ram,
    output logic        read_enable_to_ram,
    output logic        enable_ram_read,
    output logic [15:0] D
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    localparam logic [3:0] OP_ALU = 4'h0;
    localparam logic [3:0] OP_LI  = 4'h8;
    localparam logic [3:0] OP_LW  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_BZ  = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
`ifdef CPU_BNZ_EN
    localparam logic [3:0] OP_BNZ = 4'hD;
`endif

    logic [0:0]  state;
    logic [5:0]  pc;
    logic [15:0] ir;
    logic [15:0] regs [16];

    logic [3:0]  op, rd, rs, fn;
    logic [7:0]  imm8;
    logic [15:0] rd_val, rs_val;
    logic        in_exec, is_lw, is_sw;
    logic [5:0]  pc_inc, pc_br, pc_next;
    logic        wb_en;
    logic [15:0] wb_val;

    assign op     = ir[15:12];
    assign rd     = ir[11:8];
    assign rs     = ir[7:4];
    assign fn     = ir[3:0];
    assign imm8   = ir[7:0];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    // Gating with reset keeps every strobe low and the bus released during reset.
    assign in_exec = reset && (state == ST_EXEC);
    assign is_lw   = in_exec && (op == OP_LW);
    assign is_sw   = in_exec && (op == OP_SW);

    // Low 6 bits of the sign-extended offset suffice since the PC wraps mod 64.
    assign pc_inc = pc + 6'd1;
    assign pc_br  = pc_inc + imm8[5:0];

    always_comb begin
        wb_en   = 1'b0;
        wb_val  = 16'h0000;
        pc_next = pc_inc;
        case (op)
            OP_ALU: begin
                wb_en = 1'b1;
                case (fn)
                    4'h0:    wb_val = rs_val;
                    4'h1:    wb_val = rd_val + rs_val;
                    4'h2:    wb_val = rd_val - rs_val;
                    4'h3:    wb_val = rd_val & rs_val;
                    4'h4:    wb_val = rd_val | rs_val;
                    4'h5:    wb_val = rd_val ^ rs_val;
                    4'h6:    wb_val = ~rs_val;
                    4'h7:    wb_val = {rd_val[14:0], 1'b0};
                    4'h8:    wb_val = {1'b0, rd_val[15:1]};
                    default: wb_en  = 1'b0;
                endcase
            end
            OP_LI: begin
                wb_en  = 1'b1;
                wb_val = {{8{imm8[7]}}, imm8};
            end
            OP_LW: begin
                wb_en  = 1'b1;
                wb_val = data_ram;
            end
            OP_BZ: begin
                if (rd_val == 16'h0000) pc_next = pc_br;
            end
`ifdef CPU_BNZ_EN
            OP_BNZ: begin
                if (rd_val != 16'h0000) pc_next = pc_br;
            end
`endif
            OP_JMP:  pc_next = imm8[5:0];
            default: pc_next = pc_inc;
        endcase
    end

    assign address_to_rom      = pc;
    assign enable_to_rom       = reset && (state == ST_FETCH);
    assign address_to_ram      = (is_lw || is_sw) ? imm8[5:0] : 6'd0;
    assign read_enable_to_ram  = is_lw;
    assign write_enable_to_ram = is_sw;
    assign enable_ram_read     = is_lw || is_sw;
    assign data_ram            = is_sw ? rd_val : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_FETCH;
            pc    <= 6'd0;
            ir    <= 16'h0000;
            D     <= 16'h0000;
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
        end else if (state == ST_FETCH) begin
            ir    <= data_from_rom;
            state <= ST_EXEC;
        end else begin
            if (wb_en) begin
                regs[rd] <= wb_val;
                D        <= wb_val;
            end
            pc    <= pc_next;
            state <= ST_FETCH;
        end
    end

endmodule

// File: tb/tb_risc16_cpu.sv
// Directed bench for risc16_cpu: a program table stepped instruction by instruction plus reset corner cases.
module tb_risc16_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] data_from_rom;
    logic [5:0]  address_to_rom;
    logic        enable_to_rom;
    wire  [15:0] data_ram;
    logic [5:0]  address_to_ram;
    logic        write_enable_to_ram;
    logic        read_enable_to_ram;
    logic        enable_ram_read;
    logic [15:0] D;

    logic [15:0] rom [64];
    logic [15:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CPU_BNZ_EN
    localparam logic [5:0] BNZ_TGT = 6'd29;
`else
    localparam logic [5:0] BNZ_TGT = 6'd24;
`endif

    typedef struct {
        logic [5:0]  pc;
        logic [15:0] ins;
        logic [15:0] d;
        logic [5:0]  npc;
        logic        re;
        logic        we;
        logic [5:0]  ra;
        logic [15:0] wd;
    } vec_t;

    vec_t tbl [$];

    risc16_cpu dut (
        .clk                 (clk),
        .reset               (reset),
        .data_from_rom       (data_from_rom),
        .address_to_rom      (address_to_rom),
        .enable_to_rom       (enable_to_rom),
        .data_ram            (data_ram),
        .address_to_ram      (address_to_ram),
        .write_enable_to_ram (write_enable_to_ram),
        .read_enable_to_ram  (read_enable_to_ram),
        .enable_ram_read     (enable_ram_read),
        .D                   (D)
    );

    assign data_from_rom = rom[address_to_rom];
    assign data_ram      = read_enable_to_ram ? mem[address_to_ram] : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // RAM write is captured from stable signals just before the edge that commits it.
    task automatic step();
        if (write_enable_to_ram) mem[address_to_ram] = data_ram;
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] pc, input logic [15:0] ins,
                                input logic [15:0] d, input logic [5:0] npc);
        vec_t v;
        v.pc = pc; v.ins = ins; v.d = d; v.npc = npc;
        v.re = 1'b0; v.we = 1'b0; v.ra = 6'd0; v.wd = 16'h0000;
        return v;
    endfunction

    initial begin
        vec_t v;

        tbl.push_back(mk(6'd0,  16'hF000, 16'h0000, 6'd1));
        tbl.push_back(mk(6'd1,  16'h88FF, 16'hFFFF, 6'd2));
        tbl.push_back(mk(6'd2,  16'hB8F0, 16'hFFFF, 6'd3));
        tbl.push_back(mk(6'd3,  16'h8800, 16'h0000, 6'd4));
        tbl.push_back(mk(6'd4,  16'hF000, 16'h0000, 6'd5));
        tbl.push_back(mk(6'd5,  16'hB8F0, 16'h0000, 6'd54));
        tbl.push_back(mk(6'd54, 16'h8302, 16'h0002, 6'd55));
        v = mk(6'd55, 16'h9205, 16'h0045, 6'd56); v.re = 1'b1; v.ra = 6'd5;
        tbl.push_back(v);
        tbl.push_back(mk(6'd56, 16'h0321, 16'h0047, 6'd57));
        v = mk(6'd57, 16'hA30A, 16'h0047, 6'd58); v.we = 1'b1; v.ra = 6'd10; v.wd = 16'h0047;
        tbl.push_back(v);
        tbl.push_back(mk(6'd58, 16'h8401, 16'h0001, 6'd59));
        tbl.push_back(mk(6'd59, 16'h8500, 16'h0000, 6'd60));
        tbl.push_back(mk(6'd60, 16'h0542, 16'hFFFF, 6'd61));
        tbl.push_back(mk(6'd61, 16'hC00A, 16'hFFFF, 6'd10));
        tbl.push_back(mk(6'd10, 16'h0556, 16'h0000, 6'd11));
        tbl.push_back(mk(6'd11, 16'h8681, 16'hFF81, 6'd12));
        tbl.push_back(mk(6'd12, 16'h0667, 16'hFF02, 6'd13));
        tbl.push_back(mk(6'd13, 16'h0668, 16'h7F81, 6'd14));
        tbl.push_back(mk(6'd14, 16'h8733, 16'h0033, 6'd15));
        tbl.push_back(mk(6'd15, 16'h0763, 16'h0001, 6'd16));
        tbl.push_back(mk(6'd16, 16'h0764, 16'h7F81, 6'd17));
        tbl.push_back(mk(6'd17, 16'h0745, 16'h7F80, 6'd18));
        tbl.push_back(mk(6'd18, 16'h0749, 16'h7F80, 6'd19));
        tbl.push_back(mk(6'd19, 16'h0740, 16'h0001, 6'd20));
        tbl.push_back(mk(6'd20, 16'h0441, 16'h0002, 6'd21));
        tbl.push_back(mk(6'd21, 16'h8980, 16'hFF80, 6'd22));
        tbl.push_back(mk(6'd22, 16'h0991, 16'hFF00, 6'd23));
        tbl.push_back(mk(6'd23, 16'hD905, 16'hFF00, BNZ_TGT));
        tbl.push_back(mk(BNZ_TGT, 16'hC01E, 16'hFF00, 6'd30));
        tbl.push_back(mk(6'd30, 16'hB0E0, 16'hFF00, 6'd63));
        tbl.push_back(mk(6'd63, 16'h8A7F, 16'h007F, 6'd0));

        for (int i = 0; i < 64; i++) begin
            rom[i] = 16'hF000;
            mem[i] = 16'h0000;
        end
        mem[5]  = 16'h0045;
        mem[13] = 16'hBEEF;
        foreach (tbl[i]) rom[tbl[i].pc] = tbl[i].ins;

        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst en_rom", enable_to_rom, 1'b0);
        chk("rst re", read_enable_to_ram, 1'b0);
        chk("rst we", write_enable_to_ram, 1'b0);
        chk("rst en_ram", enable_ram_read, 1'b0);
        chk("rst addr_ram", address_to_ram, 6'd0);
        chk("rst D", D, 16'h0000);
        chk("rst pc", address_to_rom, 6'd0);
        reset = 1'b1;
        #1;

        foreach (tbl[i]) begin
            v = tbl[i];
            chk($sformatf("v%0d fetch pc", i), address_to_rom, v.pc);
            chk($sformatf("v%0d fetch en_rom", i), enable_to_rom, 1'b1);
            chk($sformatf("v%0d fetch en_ram", i), enable_ram_read, 1'b0);
            chk($sformatf("v%0d fetch addr_ram", i), address_to_ram, 6'd0);
            step();
            chk($sformatf("v%0d exec en_rom", i), enable_to_rom, 1'b0);
            chk($sformatf("v%0d exec pc", i), address_to_rom, v.pc);
            chk($sformatf("v%0d exec re", i), read_enable_to_ram, v.re);
            chk($sformatf("v%0d exec we", i), write_enable_to_ram, v.we);
            chk($sformatf("v%0d exec en_ram", i), enable_ram_read, v.re | v.we);
            chk($sformatf("v%0d exec addr_ram", i), address_to_ram, v.ra);
            if (v.we) chk($sformatf("v%0d exec wdata", i), data_ram, v.wd);
            step();
            chk($sformatf("v%0d D", i), D, v.d);
            chk($sformatf("v%0d next pc", i), address_to_rom, v.npc);
        end
        chk("ram[10] after SW", mem[10], 16'h0047);
        chk("ram[5] untouched", mem[5], 16'h0045);

        // Reset arriving during the EXEC cycle of a store must abort it.
        reset  = 1'b0;
        rom[0] = 16'h8355;
        rom[1] = 16'hA30C;
        step();
        reset = 1'b1;
        #1;
        step();
        step();
        chk("abort LI D", D, 16'h0055);
        chk("abort pc", address_to_rom, 6'd1);
        step();
        chk("abort exec we", write_enable_to_ram, 1'b1);
        chk("abort exec addr", address_to_ram, 6'd12);
        chk("abort exec wdata", data_ram, 16'h0055);
        reset = 1'b0;
        #1;
        chk("abort rst we", write_enable_to_ram, 1'b0);
        chk("abort rst en_ram", enable_ram_read, 1'b0);
        chk("abort rst addr_ram", address_to_ram, 6'd0);
        rom[0] = 16'hA30D;
        step();
        chk("abort no write", mem[12], 16'h0000);
        chk("abort D cleared", D, 16'h0000);
        chk("abort pc cleared", address_to_rom, 6'd0);
        chk("abort rst en_rom", enable_to_rom, 1'b0);
        reset = 1'b1;
        #1;
        chk("post rst en_rom", enable_to_rom, 1'b1);
        chk("post rst pc", address_to_rom, 6'd0);
        step();
        chk("post rst sw we", write_enable_to_ram, 1'b1);
        chk("post rst sw addr", address_to_ram, 6'd13);
        chk("post rst R3 zero", data_ram, 16'h0000);
        step();
        chk("post rst mem[13]", mem[13], 16'h0000);
        chk("post rst next pc", address_to_rom, 6'd1);
        chk("post rst D holds", D, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
